// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 sequencing constants, state encoding and word-order helper
// Contents:
//   SHA256_IV   - FIPS 180-4 initial hash, packed H7..H0 (H0 in bits [31:0])
//   seq_state_t - sequencer FSM states
//   word_rev    - reverses the order of the eight 32-bit words in a 256-bit value
package sha_pkg;
   localparam logic [255:0] SHA256_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };
   typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, OUT} seq_state_t;
   function automatic logic [255:0] word_rev(input logic [255:0] h);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = h[255-32*i -: 32];
      return r;
   endfunction
endpackage

// File: rtl/sha_seq_watchdog.sv
// sha_seq_watchdog: cycle watchdog for the core handshake wait states
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   load         - clear the count (entry to START)
//   en           - count this cycle (sequencer waiting on the core)
//   expire       - this enabled cycle is the TIMEOUT_CYCLES-th one
module sha_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt;
   assign expire = en && (cnt == W'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else if (load) cnt <= '0;
      else if (en && !expire) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/sha_block_sequencer.sv
// sha_block_sequencer: chains padded 512-bit blocks through an external SHA-256 core
// Ports:
//   clk, reset_n                        - clock, asynchronous active-low reset
//   blk_valid/blk_ready/blk_data        - block stream (word 0 in MSBs)
//   blk_first/blk_last                  - message start (use IV) / end (emit digest)
//   abort                               - synchronous abort of the current message
//   dig_valid/dig_ready/digest          - digest stream (H0 in bits [255:224])
//   dig_blocks                          - blocks hashed for this message
//   busy, error                         - not idle; sticky drop/timeout flag
//   core_first_state                    - one-cycle start pulse to the core
//   core_initial_state                  - chaining value, H0 in bits [31:0]
//   core_message_block                  - block being hashed
//   core_status/core_hash/core_valid_block - core idle flag, result, result valid
module sha_block_sequencer #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               blk_valid,
   output logic               blk_ready,
   input  logic [511:0]       blk_data,
   input  logic               blk_first,
   input  logic               blk_last,
   input  logic               abort,
   output logic               dig_valid,
   input  logic               dig_ready,
   output logic [255:0]       digest,
   output logic [CNT_W-1:0]   dig_blocks,
   output logic               busy,
   output logic               error,
   output logic               core_first_state,
   output logic [255:0]       core_initial_state,
   output logic [511:0]       core_message_block,
   input  logic               core_status,
   input  logic [255:0]       core_hash,
   input  logic               core_valid_block
);
   import sha_pkg::*;
   seq_state_t         state, state_n;
   logic               in_msg, last_q;
   logic [255:0]       hash_reg;
   logic [CNT_W-1:0]   counter;
   logic               accept, drop, capture, timeout, wd_en, wd_expire;
   assign wd_en              = (state == WAIT_ACK) || (state == WAIT_DONE);
   assign busy               = state != IDLE;
   assign dig_valid          = state == OUT;
   assign core_first_state   = state == START;
   assign digest             = hash_reg;
   assign dig_blocks         = counter;
   sha_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept),
      .en      (wd_en),
      .expire  (wd_expire)
   );
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      drop    = 1'b0;
      capture = 1'b0;
      timeout = 1'b0;
      if (abort) state_n = IDLE;
      else begin
         case (state)
            IDLE: if (blk_valid && blk_ready) begin
               accept  = blk_first || in_msg;
               drop    = !accept;
               state_n = accept ? START : IDLE;
            end
            START: state_n = WAIT_ACK;
            WAIT_ACK: begin
               timeout = wd_expire;
               state_n = wd_expire ? IDLE : (!core_status ? WAIT_DONE : WAIT_ACK);
            end
            WAIT_DONE: begin
               // a completion seen on the expiring cycle still counts as success
               capture = core_status && core_valid_block;
               timeout = wd_expire && !capture;
               state_n = capture ? (last_q ? OUT : IDLE) : (timeout ? IDLE : WAIT_DONE);
            end
            OUT: state_n = dig_ready ? IDLE : OUT;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         blk_ready          <= 1'b0;
         in_msg             <= 1'b0;
         last_q             <= 1'b0;
         hash_reg           <= '0;
         counter            <= '0;
         error              <= 1'b0;
         core_initial_state <= '0;
         core_message_block <= '0;
      end else begin
         state     <= state_n;
         // only offered while idle and the core reported idle last cycle
         blk_ready <= (state_n == IDLE) && core_status;
         if (abort) begin
            in_msg  <= 1'b0;
            counter <= '0;
         end else begin
            if (accept) begin
               core_message_block <= blk_data;
               last_q             <= blk_last;
               core_initial_state <= blk_first ? SHA256_IV : word_rev(hash_reg);
               counter            <= blk_first ? CNT_W'(1) : (&counter ? counter : counter + 1'b1);
               if (blk_first) error <= 1'b0;
            end
            if (drop || timeout) error <= 1'b1;
            if (timeout) in_msg <= 1'b0;
            if (capture) begin
               hash_reg <= core_hash;
               if (!last_q) in_msg <= 1'b1;
            end
            if (state == OUT && dig_ready) in_msg <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sha_block_sequencer.sv
// tb_sha_block_sequencer: directed bench with a behavioural SHA-256 core and a digest scoreboard
module tb_sha_block_sequencer;
   localparam int TO = 256;
   localparam logic [255:0] ABC_DIG = 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
   localparam logic [255:0] MID_DIG = 256'h85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A;
   localparam logic [255:0] TWO_DIG = 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
   localparam logic [2047:0] KC = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   logic clk = 1'b0, reset_n = 1'b0;
   logic blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, abort = 1'b0, dig_ready = 1'b0;
   logic [511:0] blk_data = '0;
   logic blk_ready, dig_valid, busy, error, core_first_state;
   logic [255:0] digest, core_initial_state;
   logic [15:0] dig_blocks;
   logic [511:0] core_message_block;
   logic core_status = 1'b1, core_valid_block = 1'b0, hang = 1'b0;
   logic [255:0] core_hash = '0, pend = '0;
   int lat = 0, pulses = 0, total = 0, bad = 0;
   typedef struct {logic [255:0] d; logic [15:0] n;} exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   sha_block_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last), .abort(abort),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .dig_blocks(dig_blocks),
      .busy(busy), .error(error), .core_first_state(core_first_state),
      .core_initial_state(core_initial_state), .core_message_block(core_message_block),
      .core_status(core_status), .core_hash(core_hash), .core_valid_block(core_valid_block)
   );
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   // one SHA-256 compression; cv has H0 in [31:0], result has H0 in [255:224]
   function automatic logic [255:0] sha_comp(input logic [255:0] cv, input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] hv [8];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin hv[i] = cv[32*i +: 32]; v[i] = hv[i]; end
      for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
              + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
            + KC[2047-32*t -: 32] + w[t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
      return r;
   endfunction
   // behavioural core: drops status after a start, finishes a few cycles later unless hung
   always @(posedge clk) begin
      if (core_first_state) begin
         core_status      <= 1'b0;
         core_valid_block <= 1'b0;
         lat              <= 4;
         pend             <= sha_comp(core_initial_state, core_message_block);
      end else if (!core_status && !hang) begin
         if (lat == 0) begin
            core_status      <= 1'b1;
            core_valid_block <= 1'b1;
            core_hash        <= pend;
         end else lat <= lat - 1;
      end
   end
   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (core_first_state) pulses++;
      if (dig_valid && dig_ready) begin
         if (sb.size() == 0) chk("unexpected_digest", 1'b1, 1'b0);
         else begin
            chk("digest", digest, sb[0].d);
            chk("dig_blocks", dig_blocks, sb[0].n);
            void'(sb.pop_front());
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [511:0] d, input logic f, input logic l);
      int i;
      blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
      for (i = 0; i < 2000 && !blk_ready; i++) tick();
      chk("blk_ready_wait", blk_ready, 1'b1);
      tick();
      blk_valid = 1'b0;
   endtask
   task automatic take_dig();
      int i;
      for (i = 0; i < 2000 && !dig_valid; i++) tick();
      chk("dig_valid_wait", dig_valid, 1'b1);
      dig_ready = 1'b1;
      tick();
      dig_ready = 1'b0;
   endtask
   logic [511:0] abc_blk, two_b1, two_b2;
   logic [447:0] msg2;
   logic [255:0] mid_rev, d0;
   logic [15:0] n0;
   logic stable;
   int p0, n;
   initial begin
      abc_blk = {32'h61626380, 416'b0, 64'h18};
      msg2    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      two_b1  = {msg2, 8'h80, 56'b0};
      two_b2  = {448'b0, 64'h1c0};
      for (int i = 0; i < 8; i++) mid_rev[32*i +: 32] = MID_DIG[255-32*i -: 32];
      repeat (2) tick();
      chk("rst_blk_ready", blk_ready, 1'b0);
      chk("rst_dig_valid", dig_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_first_state", core_first_state, 1'b0);
      chk("rst_digest", digest, 256'b0);
      chk("rst_init_state", core_initial_state, 256'b0);
      reset_n = 1'b1;
      tick();
      chk("ready_after_rst", blk_ready, 1'b1);
      sb.push_back('{ABC_DIG, 16'd1});
      send(abc_blk, 1'b1, 1'b1);
      take_dig();
      sb.push_back('{TWO_DIG, 16'd2});
      send(two_b1, 1'b1, 1'b0);
      send(two_b2, 1'b0, 1'b1);
      chk("chain_word0", core_initial_state[31:0], 32'h85E655D6);
      chk("chain_full", core_initial_state, mid_rev);
      take_dig();
      p0 = pulses;
      send(abc_blk, 1'b0, 1'b1);
      repeat (3) tick();
      chk("drop_error", error, 1'b1);
      chk("drop_busy", busy, 1'b0);
      chk("drop_no_pulse", pulses, p0);
      sb.push_back('{ABC_DIG, 16'd1});
      send(abc_blk, 1'b1, 1'b1);
      chk("first_clears_error", error, 1'b0);
      take_dig();
      hang = 1'b1;
      send(abc_blk, 1'b1, 1'b1);
      chk("to_start", core_first_state, 1'b1);
      // START sample, then TO wait cycles, then the IDLE/error sample
      for (n = 0; n < 1000 && !error; n++) tick();
      chk("to_cycles", n, TO + 1);
      chk("to_idle", busy, 1'b0);
      hang = 1'b0;
      send(abc_blk, 1'b1, 1'b1);
      for (int i = 0; i < 2 && core_status; i++) tick();
      tick();
      chk("mid_wait_done", {busy, core_status}, 2'b10);
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_error", error, 1'b0);
      chk("arst_blocks", dig_blocks, 16'd0);
      chk("arst_msg_block", core_message_block, 512'b0);
      chk("arst_init_state", core_initial_state, 256'b0);
      chk("arst_digest", digest, 256'b0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 100 && !core_status; i++) tick();
      chk("ready_blocked", blk_ready, 1'b0);
      tick();
      chk("ready_after_core", blk_ready, 1'b1);
      send(abc_blk, 1'b1, 1'b1);
      for (int i = 0; i < 2000 && !dig_valid; i++) tick();
      d0 = digest; n0 = dig_blocks; stable = 1'b1;
      chk("hold_digest", d0, ABC_DIG);
      repeat (10) begin
         tick();
         stable &= dig_valid && digest === d0 && dig_blocks === n0;
      end
      chk("hold_stable", stable, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_dig_valid", dig_valid, 1'b0);
      chk("abort_counter", dig_blocks, 16'd0);
      chk("abort_error", error, 1'b0);
      sb.push_back('{ABC_DIG, 16'd1});
      send(abc_blk, 1'b1, 1'b1);
      take_dig();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
Sequences multi-block SHA-256 messages through one sha_math_core instance. Accepts 512-bit padded blocks over a valid/ready stream with first/last markers. Drives the core's start pulse, initial state and message block, and chains each block's hash into the next block's initial state. Presents the final digest over a valid/ready output, with a watchdog and an abort path.

Parameters:
TIMEOUT_CYCLES, 256, max cycles spent in WAIT_ACK+WAIT_DONE before error
CNT_W, 16, width of block counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
blk_valid  in  1  input block valid
blk_ready  out  1  sequencer can accept block
blk_data  in  512  padded message block, word 0 in MSBs
blk_first  in  1  block starts a new message (use IV)
blk_last  in  1  block ends message (emit digest)
abort  in  1  synchronous abort of current message
dig_valid  out  1  digest valid
dig_ready  in  1  downstream accepts digest
digest  out  256  final hash, H0 in bits [255:224]
dig_blocks  out  CNT_W  blocks hashed for this message
busy  out  1  state != IDLE
error  out  1  sticky protocol/timeout error
core_first_state  out  1  start pulse to core
core_initial_state  out  256  chaining value, H0 in bits [31:0]
core_message_block  out  512  block to core
core_status  in  1  core ready/idle
core_hash  in  256  core hash, H0 in bits [255:224]
core_valid_block  in  1  core hash valid

Behaviour:
- States: IDLE, START, WAIT_ACK, WAIT_DONE, OUT.
- Reset (async, reset_n low): state IDLE; all outputs 0; in_msg=0, hash_reg=0, counter=0, watchdog=0.
- blk_ready: registered; 1 only in IDLE when core_status was 1 the previous cycle; 0 in all other states.
- Accept occurs on blk_valid & blk_ready. On accept, latch blk_data into core_message_block and latch blk_last. Chaining value:
  - blk_first=1: IV = {5be0cd19,1f83d9ab,9b05688c,510e527f,a54ff53a,3c6ef372,bb67ae85,6a09e667} (H7..H0). Counter=1. Clear error.
  - blk_first=0 with in_msg=1: word-reverse hash_reg so that word i of core_initial_state = H_i. Counter increments.
  - blk_first=0 with in_msg=0: block dropped, error=1, stay in IDLE.
  - Next state START.
- START: core_first_state=1 for exactly one cycle; go to WAIT_ACK. core_message_block and core_initial_state are held stable from accept until the next accept.
- WAIT_ACK: wait for core_status=0, then go to WAIT_DONE.
- WAIT_DONE: wait for core_status=1 & core_valid_block=1. Capture core_hash into hash_reg.
  - last=1: go to OUT.
  - last=0: set in_msg=1 and go to IDLE.
- Watchdog: cleared on entry to START. Increments in WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT_CYCLES: error=1, in_msg=0, go to IDLE.
- OUT: dig_valid=1; digest=hash_reg and dig_blocks=counter, both stable while dig_valid & !dig_ready. On dig_ready: dig_valid=0, in_msg=0, go to IDLE.
- Minimum latency is 1 cycle for START plus core latency plus 1 cycle of capture; dig_valid rises the cycle after capture.
- abort: highest priority (below reset), honoured in any state. Go to IDLE; dig_valid=0, in_msg=0, counter=0. error is unchanged. Because blk_ready requires core_status, no new start is issued while an aborted core operation is still running.
- Simultaneous abort and accept: abort wins; the block is not accepted.
- Counter saturates at all-ones.

Decomposition:
- Shared package sha_pkg: SHA256_IV constant (256-bit, H7..H0 order), state enum, the word-reverse function (256-bit, 8x32).
- Sub-module sha_seq_watchdog: load/enable/expire counter, parameterised by TIMEOUT_CYCLES.
- The core is instantiated in the wrapper, not inside the sequencer.

Test Plan:
- Reset mid-WAIT_DONE -> all outputs 0 immediately; blk_ready=1 one cycle after release once core_status=1.
- "abc" block 61626380…0018, first=1, last=1 -> dig_valid with digest BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD, dig_blocks=1.
- Two blocks "abcdbcde…nopq" (first, then last, 2nd = …01C0) -> intermediate hash_reg 85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A; chained core_initial_state word0=85E655D6; digest 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1, dig_blocks=2.
- blk_first=0 after reset -> block dropped, error=1, no core_first_state pulse; a following first=1 block clears error.
- Core model never raising core_status -> error=1 after exactly TIMEOUT_CYCLES=256 wait cycles; state returns to IDLE.
- dig_ready held low for 10 cycles, then abort -> digest stable for the 10 cycles; dig_valid drops the cycle after abort; next "abc" block hashes correctly.
